// File: rtl/mips_if_pf.sv
// mips_if_pf: prefetching instruction fetch with request credits, in-order response pairing and a prefetch FIFO.
// Optional static prediction at enqueue is compiled in when MIPS_IF_PF_BPU_EN is defined.
module mips_if_pf #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter int              DEPTH    = 4,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          I_req,
  output logic [AW-3:0] I_addr,
  input  logic          I_gnt,
  input  logic          I_rvalid,
  input  logic [DW-1:0] I_rdata,
  output logic          if2id_valid,
  input  logic          if2id_ready,
  output logic [DW-1:0] if2id_inst,
  output logic [AW-1:0] if2id_pc_incr,
  output logic          if2id_prdt_taken,
  input  logic          ex_redirect,
  input  logic [AW-1:0] ex_redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, sh_rd_q, sh_rd_d, sh_wr_q, sh_wr_d;

  logic [DW-1:0] fifo_inst_q [DEPTH];
  logic [AW-1:0] fifo_pc_q   [DEPTH];
  logic          fifo_prdt_q [DEPTH];
  logic [AW-1:0] sh_pc_q     [DEPTH];

  logic [CW:0]   credit;
  logic          gnt, deq, enq, take, sh_push, pred_taken;
  logic [AW-1:0] pc_plus4, rsp_pc, pred_tgt;

  assign credit      = {1'b0, count_q} + {1'b0, inflight_q};
  assign I_req       = rst_n & ~ex_redirect & (credit < (CW+1)'(DEPTH));
  assign I_addr      = pc_q[AW-1:2];
  assign gnt         = I_req & I_gnt;
  assign if2id_valid = (count_q != '0);
  assign deq         = if2id_valid & if2id_ready;
  assign pc_plus4    = pc_q + AW'(4);
  assign rsp_pc      = sh_pc_q[sh_rd_q];

  // Outputs are forced to zero while the FIFO is empty so reset leaves them clean without resetting storage.
  assign if2id_inst       = if2id_valid ? fifo_inst_q[rd_q] : '0;
  assign if2id_pc_incr    = if2id_valid ? fifo_pc_q[rd_q]   : '0;
  assign if2id_prdt_taken = if2id_valid & fifo_prdt_q[rd_q];

`ifdef MIPS_IF_PF_BPU_EN
  function automatic logic pred_taken_f(input logic [DW-1:0] inst);
    if (inst[31:27] == 5'b00001) return 1'b1;
    if (inst[31:28] == 4'b0001)  return inst[15];
    return 1'b0;
  endfunction

  function automatic logic [AW-1:0] pred_target_f(input logic [DW-1:0] inst,
                                                  input logic [AW-1:0] pc_incr);
    logic signed [AW-1:0] off;
    off = {{(AW-18){inst[15]}}, inst[15:0], 2'b00};
    if (inst[31:27] == 5'b00001) return {pc_incr[AW-1:28], inst[25:0], 2'b00};
    return pc_incr + $unsigned(off);
  endfunction

  assign pred_taken = pred_taken_f(I_rdata);
  assign pred_tgt   = pred_target_f(I_rdata, rsp_pc);
`else
  assign pred_taken = 1'b0;
  assign pred_tgt   = '0;
`endif

  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    sh_rd_d    = sh_rd_q;
    sh_wr_d    = sh_wr_q;
    enq        = 1'b0;
    take       = 1'b0;
    sh_push    = 1'b0;
    if (ex_redirect) begin
      // Everything still in flight belongs to the old path, except a response landing right now.
      pc_d       = ex_redirect_pc;
      count_d    = '0;
      rd_d       = '0;
      wr_d       = '0;
      sh_rd_d    = '0;
      sh_wr_d    = '0;
      inflight_d = inflight_q - CW'(I_rvalid);
      drop_d     = inflight_d;
    end else begin
      inflight_d = inflight_q + CW'(gnt) - CW'(I_rvalid);
      if (I_rvalid && drop_q != '0) begin
        drop_d = drop_q - CW'(1);
      end else if (I_rvalid) begin
        enq     = 1'b1;
        sh_rd_d = sh_rd_q + PW'(1);
      end
      take = enq & pred_taken;
      if (take) begin
        // Requests younger than the taken instruction, including a same-cycle grant, are wrong-path.
        pc_d    = pred_tgt;
        drop_d  = inflight_d;
        sh_rd_d = '0;
        sh_wr_d = '0;
      end else if (gnt) begin
        pc_d    = pc_plus4;
        sh_push = 1'b1;
        sh_wr_d = sh_wr_q + PW'(1);
      end
      if (enq) wr_d = wr_q + PW'(1);
      if (deq) rd_d = rd_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      sh_rd_q    <= '0;
      sh_wr_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      sh_rd_q    <= sh_rd_d;
      sh_wr_q    <= sh_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_inst_q[wr_q] <= I_rdata;
      fifo_pc_q[wr_q]   <= rsp_pc;
      fifo_prdt_q[wr_q] <= take;
    end
    if (sh_push) sh_pc_q[sh_wr_q] <= pc_plus4;
  end

endmodule

// File: tb/tb_mips_if_pf.sv
// Testbench for mips_if_pf: memory model with random grant/latency and a program-order reference of the fetch stream.
module tb_mips_if_pf;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;
`ifdef MIPS_IF_PF_BPU_EN
  localparam bit BPU = 1'b1;
`else
  localparam bit BPU = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          I_req;
  logic [AW-3:0] I_addr;
  logic          I_gnt = 1'b0;
  logic          I_rvalid = 1'b0;
  logic [DW-1:0] I_rdata = '0;
  logic          if2id_valid;
  logic          if2id_ready = 1'b0;
  logic [DW-1:0] if2id_inst;
  logic [AW-1:0] if2id_pc_incr;
  logic          if2id_prdt_taken;
  logic          ex_redirect = 1'b0;
  logic [AW-1:0] ex_redirect_pc = '0;

  always #5 clk = ~clk;

  mips_if_pf #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .I_req(I_req), .I_addr(I_addr), .I_gnt(I_gnt),
    .I_rvalid(I_rvalid), .I_rdata(I_rdata), .if2id_valid(if2id_valid),
    .if2id_ready(if2id_ready), .if2id_inst(if2id_inst), .if2id_pc_incr(if2id_pc_incr),
    .if2id_prdt_taken(if2id_prdt_taken), .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc)
  );

  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t        mq[$];
  logic [31:0] prog [logic [31:0]];

  int total = 0;
  int bad = 0;
  int cyc, n_gnt, n_del;
  int unsigned gnt_pct, rdy_pct, lat_min, lat_max;
  logic        redir_req = 1'b0;
  logic [31:0] redir_pc = '0;
  logic [31:0] exp_pc;
  logic        o_req, o_valid, o_rvalid;
  logic [31:0] o_addr, o_rdata;
  logic        d_fire, d_prdt, e_prdt;
  logic [31:0] d_inst, d_pc, e_inst, e_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (prog.exists(a)) return prog[a];
    return {6'b000000, (a[27:2] * 26'd2654435) ^ 26'h15A5A5A};
  endfunction

  function automatic logic m_taken(input logic [31:0] inst);
    int op;
    op = int'(inst[31:26]);
    if (!BPU) return 1'b0;
    if (op == 2 || op == 3) return 1'b1;
    if (op >= 4 && op <= 7) return inst[15];
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] inst, input logic [31:0] pc_incr);
    int off;
    if (inst[31:26] == 6'd2 || inst[31:26] == 6'd3) return {pc_incr[31:28], inst[25:0], 2'b00};
    off = int'($signed(inst[15:0]));
    return pc_incr + 32'(off * 4);
  endfunction

  task automatic set_mode(input int unsigned g, input int unsigned r, input int unsigned lmin, input int unsigned lmax);
    gnt_pct = g; rdy_pct = r; lat_min = lmin; lat_max = lmax;
  endtask

  // One clock: drive inputs at negedge, record what happens at the next posedge, advance the reference.
  task automatic cycle();
    @(negedge clk);
    rst_n = 1'b1;
    I_gnt = ($urandom_range(0, 99) < gnt_pct);
    if2id_ready = ($urandom_range(0, 99) < rdy_pct);
    ex_redirect = redir_req;
    ex_redirect_pc = redir_pc;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      I_rvalid = 1'b1; I_rdata = mem_word(mq[0].addr);
    end else begin
      I_rvalid = 1'b0; I_rdata = $urandom;
    end
    #1;
    o_req = I_req; o_addr = {I_addr, 2'b00}; o_valid = if2id_valid;
    o_rvalid = I_rvalid; o_rdata = I_rdata;
    d_fire = if2id_valid & if2id_ready;
    d_inst = if2id_inst; d_pc = if2id_pc_incr; d_prdt = if2id_prdt_taken;
    e_inst = mem_word(exp_pc); e_pc = exp_pc + 32'd4; e_prdt = m_taken(e_inst);
    if (d_fire) begin
      exp_pc = e_prdt ? m_target(e_inst, e_pc) : e_pc;
      n_del++;
    end
    if (ex_redirect) exp_pc = ex_redirect_pc;
    if (I_req && I_gnt) begin
      mq.push_back('{addr: o_addr, due: cyc + int'($urandom_range(lat_min, lat_max))});
      n_gnt++;
    end
    if (I_rvalid) void'(mq.pop_front());
    redir_req = 1'b0;
    @(posedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; I_gnt = 1'b0; I_rvalid = 1'b0; if2id_ready = 1'b0; ex_redirect = 1'b0;
    redir_req = 1'b0;
    mq.delete();
    prog.delete();
    exp_pc = 32'h0;
    @(posedge clk);
    #1;
    cyc = 1; n_gnt = 0; n_del = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (I_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", I_req); end
    total++; if (if2id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", if2id_valid); end
    total++; if (if2id_prdt_taken !== 1'b0) begin bad++; $display("FAIL reset_prdt got=%b want=0", if2id_prdt_taken); end
    total++; if (if2id_inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h want=0", if2id_inst); end
    total++; if (if2id_pc_incr !== 32'h0) begin bad++; $display("FAIL reset_pc_incr got=%h want=0", if2id_pc_incr); end
  endtask

  task automatic test_stream();
    apply_reset();
    set_mode(100, 100, 1, 1);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      total++;
      if (o_req !== 1'b1 || o_addr !== 32'(4 * (k - 1)))
        begin bad++; $display("FAIL stream_issue cyc=%0d got req=%b addr=%h want req=1 addr=%h", k, o_req, o_addr, 32'(4 * (k - 1))); end
      if (k >= 3) begin
        total++;
        if (d_fire !== 1'b1 || d_pc !== 32'(4 * (k - 2)) || d_inst !== mem_word(32'(4 * (k - 3))) || d_prdt !== 1'b0)
          begin bad++; $display("FAIL stream_deliver cyc=%0d got fire=%b pc=%h inst=%h want pc=%h", k, d_fire, d_pc, d_inst, 32'(4 * (k - 2))); end
      end
    end
  endtask

  task automatic test_stall();
    int got;
    apply_reset();
    set_mode(100, 0, 1, 1);
    for (int k = 0; k < 10; k++) cycle();
    total++; if (n_gnt !== 4) begin bad++; $display("FAIL stall_grants got=%0d want=4", n_gnt); end
    total++; if (o_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%b want=0", o_req); end
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", o_valid); end
    set_mode(100, 100, 1, 1);
    got = 0;
    for (int k = 0; k < 40 && got < 8; k++) begin
      cycle();
      if (d_fire) begin
        got++;
        total++;
        if (d_inst !== e_inst || d_pc !== e_pc || d_prdt !== e_prdt)
          begin bad++; $display("FAIL stall_deliver got pc=%h inst=%h want pc=%h inst=%h", d_pc, d_inst, e_pc, e_inst); end
      end
    end
    total++; if (got !== 8) begin bad++; $display("FAIL stall_release got=%0d want=8 deliveries", got); end
    total++; if (n_gnt <= 4) begin bad++; $display("FAIL stall_resume got grants=%0d want >4", n_gnt); end
  endtask

  task automatic test_redirect();
    int got;
    apply_reset();
    set_mode(100, 100, 5, 5);
    cycle(); cycle(); cycle();
    total++; if (n_gnt !== 3) begin bad++; $display("FAIL redir_inflight got=%0d want=3", n_gnt); end
    redir_req = 1'b1; redir_pc = 32'h100; gnt_pct = 0;
    cycle();
    total++; if (o_req !== 1'b0) begin bad++; $display("FAIL redir_req_same got=%b want=0", o_req); end
    set_mode(100, 100, 1, 1);
    cycle();
    total++;
    if (o_req !== 1'b1 || o_addr !== 32'h100)
      begin bad++; $display("FAIL redir_next_issue got req=%b addr=%h want req=1 addr=100", o_req, o_addr); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got valid=%b want=0", o_valid); end
    got = 0;
    for (int k = 0; k < 40 && got < 6; k++) begin
      cycle();
      if (d_fire) begin
        if (got == 0) begin
          total++;
          if (d_pc !== 32'h104) begin bad++; $display("FAIL redir_first got=%h want=104", d_pc); end
        end
        got++;
        total++;
        if (d_inst !== e_inst || d_pc !== e_pc || d_prdt !== e_prdt)
          begin bad++; $display("FAIL redir_deliver got pc=%h inst=%h want pc=%h inst=%h", d_pc, d_inst, e_pc, e_inst); end
      end
    end
    total++; if (got !== 6) begin bad++; $display("FAIL redir_live got=%0d want=6", got); end
  endtask

  task automatic test_bpu_branch();
    logic [31:0] prev;
    int hits;
    apply_reset();
    prog[32'h40] = 32'h1000FFFF;
    set_mode(100, 100, 1, 1);
    prev = '0; hits = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (d_fire) begin
        total++;
        if (d_inst !== e_inst || d_pc !== e_pc || d_prdt !== e_prdt)
          begin bad++; $display("FAIL bra_deliver got pc=%h inst=%h prdt=%b want pc=%h inst=%h prdt=%b", d_pc, d_inst, d_prdt, e_pc, e_inst, e_prdt); end
        if (d_pc == 32'h44) begin
          total++;
          if (d_prdt !== BPU) begin bad++; $display("FAIL bra_prdt got=%b want=%b", d_prdt, BPU); end
        end
        if (prev == 32'h44) begin
          hits++;
          total++;
          if (d_pc !== (BPU ? 32'h44 : 32'h48)) begin bad++; $display("FAIL bra_next got=%h want=%h", d_pc, BPU ? 32'h44 : 32'h48); end
        end
        prev = d_pc;
      end
    end
    total++; if (hits < 1) begin bad++; $display("FAIL bra_reach got=%0d want>=1", hits); end
  endtask

  task automatic test_bpu_jump();
    logic armed;
    int   seen;
    apply_reset();
    prog[32'h8] = 32'h0800_0040;
    set_mode(100, 100, 1, 1);
    armed = 1'b0; seen = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (armed) begin
        seen++;
        total++;
        if (o_req !== 1'b1 || o_addr !== (BPU ? 32'h100 : 32'h10))
          begin bad++; $display("FAIL jump_fetch got req=%b addr=%h want addr=%h", o_req, o_addr, BPU ? 32'h100 : 32'h10); end
      end
      armed = o_rvalid && (o_rdata == 32'h0800_0040);
      if (d_fire) begin
        total++;
        if (d_inst !== e_inst || d_pc !== e_pc || d_prdt !== e_prdt)
          begin bad++; $display("FAIL jump_deliver got pc=%h prdt=%b want pc=%h prdt=%b", d_pc, d_prdt, e_pc, e_prdt); end
      end
    end
    total++; if (seen !== 1) begin bad++; $display("FAIL jump_seen got=%0d want=1", seen); end
  endtask

  task automatic test_ex_vs_bpu();
    logic done;
    int   after;
    apply_reset();
    prog[32'h10] = 32'h1000FFFF;
    set_mode(100, 100, 3, 3);
    done = 1'b0; after = 0;
    for (int k = 0; k < 40; k++) begin
      if (!done && mq.size() > 0 && mq[0].due <= cyc && mq[0].addr == 32'h10) begin
        redir_req = 1'b1; redir_pc = 32'h200; done = 1'b1;
      end
      cycle();
      if (d_fire) begin
        if (done && after == 0 && d_pc != 32'h14) begin
          after++;
          total++;
          if (d_pc !== 32'h204) begin bad++; $display("FAIL exbpu_first got=%h want=204", d_pc); end
        end
        total++;
        if (d_inst !== e_inst || d_pc !== e_pc || d_prdt !== e_prdt)
          begin bad++; $display("FAIL exbpu_deliver got pc=%h prdt=%b want pc=%h prdt=%b", d_pc, d_prdt, e_pc, e_prdt); end
      end
    end
    total++; if (after !== 1) begin bad++; $display("FAIL exbpu_reach got=%0d want=1", after); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      for (int i = 0; i < 12; i++) begin
        logic [31:0] a;
        a = 32'($urandom_range(0, 63)) * 32'd4;
        case ($urandom_range(0, 2))
          0:       prog[a] = {6'd2, 20'd0, 6'($urandom_range(0, 63))};
          1:       prog[a] = {6'd4, 10'($urandom), 16'hFFFF - 16'($urandom_range(0, 7))};
          default: prog[a] = {6'd5, 10'($urandom), 16'($urandom_range(1, 8))};
        endcase
      end
      set_mode(70, 70, 1, 4);
      for (int k = 0; k < 800; k++) begin
        if ($urandom_range(0, 99) < 4) begin
          redir_req = 1'b1; redir_pc = 32'($urandom_range(0, 63)) * 32'd4;
        end
        cycle();
        if (d_fire) begin
          total++;
          if (d_inst !== e_inst || d_pc !== e_pc || d_prdt !== e_prdt)
            begin bad++; $display("FAIL rand_deliver cyc=%0d got pc=%h inst=%h prdt=%b want pc=%h inst=%h prdt=%b", cyc, d_pc, d_inst, d_prdt, e_pc, e_inst, e_prdt); end
        end
      end
      total++; if (n_del < 100) begin bad++; $display("FAIL rand_live got=%0d want>=100", n_del); end
    end
  endtask

  initial begin
    set_mode(0, 0, 1, 1);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_bpu_branch();
    test_bpu_jump();
    test_ex_vs_bpu();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
